audio_adc_rx: RTL and testbench

- Receives I2S serial ADC data from the audio codec and delivers parallel signed left/right sample pairs to the design.
- Complements the existing DAC-side path: same BCLK/LRCK timing, reverse data direction.
- BCLK, ADCLRCK and ADCDAT are asynchronous to sys_clk. They are synchronized and edge-detected internally.
- Output is a frame-level valid/ready handshake with overrun indication. Volume/DSP logic sits downstream.

---
 rtl/audio_adc_rx.sv | 185 ++++++++++++++++++
 tb/tb_audio_adc_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronizes the codec serial interface into sys_clk and
// delivers left/right sample pairs through a frame-level valid/ready handshake.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         bclk,
  input  logic                         adclrc,
  input  logic                         adcdat,
  output logic signed [DATA_WIDTH-1:0] data_left,
  output logic signed [DATA_WIDTH-1:0] data_right,
  output logic                         valid,
  input  logic                         ready,
  output logic                         overrun
);

  // state    | meaning
  // ST_IDLE  | waiting for a left-slot start; right slots are ignored
  // ST_SHIFT | collecting bits of the current slot's word
  // ST_WAIT  | word complete, ignoring trailing bits until the next slot start
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT} state_t;

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrc_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_s;
  logic                   adclrc_s;
  logic                   adcdat_s;
  logic                   bclk_prev;
  logic                   lr_prev;
  logic                   rise;
  logic                   slot_start;

  state_t                 state;
  state_t                 state_n;
  logic [DATA_WIDTH-1:0]  sr;
  logic [CNT_W-1:0]       cnt;
  logic                   chan;
  logic                   start_shift;
  logic                   shift_en;
  logic                   word_done;
  logic [DATA_WIDTH-1:0]  done_word;

  logic [DATA_WIDTH-1:0]  hold;
  logic                   have_left;
  logic                   pub_pend;
  logic [DATA_WIDTH-1:0]  pub_right;

  // All three pins share the same depth so a bit stays aligned with its LR level.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      lr_prev   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], adclrc};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
      bclk_prev <= bclk_s;
      if (rise) begin
        lr_prev <= adclrc_s;
      end
    end
  end

  assign bclk_s     = bclk_sync[SYNC_STAGES-1];
  assign adclrc_s   = lrc_sync[SYNC_STAGES-1];
  assign adcdat_s   = dat_sync[SYNC_STAGES-1];
  assign rise       = bclk_s & ~bclk_prev;
  assign slot_start = rise & (adclrc_s ^ lr_prev);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    start_shift = 1'b0;
    shift_en    = 1'b0;
    word_done   = 1'b0;
    done_word   = '0;
    case (state)
      ST_IDLE: begin
        if (slot_start && !adclrc_s) begin
          start_shift = 1'b1;
          state_n     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (slot_start) begin
          // Short slot: left-justify what arrived, zeros fill the missing LSBs.
          word_done   = 1'b1;
          done_word   = sr << (FULL_CNT - cnt);
          start_shift = 1'b1;
        end else if (rise) begin
          shift_en = 1'b1;
          if (cnt == LAST_BIT) begin
            word_done = 1'b1;
            done_word = {sr[DATA_WIDTH-2:0], adcdat_s};
            state_n   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (slot_start) begin
          start_shift = 1'b1;
          state_n     = ST_SHIFT;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      cnt  <= '0;
      chan <= 1'b0;
    end else if (start_shift) begin
      sr   <= '0;
      cnt  <= '0;
      chan <= adclrc_s;
    end else if (shift_en) begin
      sr  <= {sr[DATA_WIDTH-2:0], adcdat_s};
      cnt <= cnt + 1'b1;
    end
  end

  // A right word is only paired with a left word completed earlier in the same frame.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      have_left <= 1'b0;
      pub_pend  <= 1'b0;
      pub_right <= '0;
    end else begin
      pub_pend <= 1'b0;
      if (start_shift && !adclrc_s) begin
        have_left <= 1'b0;
      end
      if (word_done) begin
        if (!chan) begin
          hold      <= done_word;
          have_left <= 1'b1;
        end else if (have_left) begin
          pub_pend  <= 1'b1;
          pub_right <= done_word;
          have_left <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      data_left  <= '0;
      data_right <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else if (pub_pend) begin
      data_left  <= hold;
      data_right <= pub_right;
      valid      <= 1'b1;
      overrun    <= valid & ~ready;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: table-driven frames plus back-pressure,
// mid-frame start and reset sequences. BCLK runs at sys_clk/16.
module tb_audio_adc_rx;

  localparam int W = 24;

  logic         sys_clk = 1'b0;
  logic         reset;
  logic         bclk;
  logic         adclrc;
  logic         adcdat;
  logic         ready;
  logic         valid;
  logic         overrun;
  logic [W-1:0] data_left;
  logic [W-1:0] data_right;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   lsb_edge = 0;
  int   rise_edge = 0;
  int   valid_rises = 0;
  int   ovr_cnt = 0;
  logic valid_q = 1'b0;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          nbits;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    bit          lat;
  } vec_t;

  vec_t vecs[4];

  always #5 sys_clk = ~sys_clk;

  audio_adc_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .bclk       (bclk),
    .adclrc     (adclrc),
    .adcdat     (adcdat),
    .data_left  (data_left),
    .data_right (data_right),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun)
  );

  always @(posedge sys_clk) edge_cnt++;

  always @(negedge sys_clk) begin
    if (valid && !valid_q) begin
      valid_rises++;
      rise_edge = edge_cnt;
    end
    if (overrun) ovr_cnt++;
    valid_q = valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bclk_bit(input logic lrc, input logic dat, input bit m);
    @(negedge sys_clk);
    bclk = 1'b0;
    adclrc = lrc;
    adcdat = dat;
    repeat (8) @(negedge sys_clk);
    bclk = 1'b1;
    if (m) lsb_edge = edge_cnt;
    repeat (7) @(negedge sys_clk);
  endtask

  task automatic send_slot(input logic lrc, input logic [31:0] word, input int nbits, input bit m);
    bclk_bit(lrc, 1'b0, 1'b0);
    for (int i = nbits - 1; i >= 0; i--) bclk_bit(lrc, word[i], m && (i == 0));
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits, input bit m);
    send_slot(1'b0, l, nbits, 1'b0);
    send_slot(1'b1, r, nbits, m);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    bclk = 1'b0;
    adclrc = 1'b0;
    adcdat = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    int v0;
    int o0;

    vecs[0] = '{l: 32'h123456,    r: 32'hFEDCBA,    nbits: 24, exp_l: 32'h123456, exp_r: 32'hFEDCBA, lat: 1'b1};
    vecs[1] = '{l: 32'h7FFFFFFF,  r: 32'h80000000,  nbits: 32, exp_l: 32'h7FFFFF, exp_r: 32'h800000, lat: 1'b0};
    vecs[2] = '{l: 32'hA5A5,      r: 32'h5A5A,      nbits: 16, exp_l: 32'hA5A500, exp_r: 32'h5A5A00, lat: 1'b0};
    vecs[3] = '{l: 32'hABCDEF,    r: 32'h000001,    nbits: 24, exp_l: 32'hABCDEF, exp_r: 32'h000001, lat: 1'b0};

    reset = 1'b1;
    bclk = 1'b0;
    adclrc = 1'b0;
    adcdat = 1'b0;
    ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset data_left", 32'(data_left), 32'h0);
    chk("reset data_right", 32'(data_right), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    reset = 1'b0;

    // A right-slot preamble gives the left slot its LR transition; the tail
    // bit starts a new left slot, which also closes a short right slot.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      ready = 1'b1;
      v0 = valid_rises;
      o0 = ovr_cnt;
      bclk_bit(1'b1, 1'b0, 1'b0);
      send_frame(vecs[i].l, vecs[i].r, vecs[i].nbits, vecs[i].lat);
      bclk_bit(1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge sys_clk);
      chk($sformatf("vec%0d data_left", i), 32'(data_left), vecs[i].exp_l);
      chk($sformatf("vec%0d data_right", i), 32'(data_right), vecs[i].exp_r);
      chk($sformatf("vec%0d valid pulses", i), 32'(valid_rises - v0), 32'd1);
      chk($sformatf("vec%0d overruns", i), 32'(ovr_cnt - o0), 32'd0);
      chk($sformatf("vec%0d valid dropped", i), 32'(valid), 32'h0);
      if (vecs[i].lat) chk("latency edges", 32'(rise_edge - lsb_edge), 32'd4);
    end

    // Back-pressure across three frames
    do_reset();
    ready = 1'b0;
    v0 = valid_rises;
    o0 = ovr_cnt;
    bclk_bit(1'b1, 1'b0, 1'b0);
    send_frame(32'h000001, 32'h000002, 24, 1'b0);
    send_frame(32'h000003, 32'h000004, 24, 1'b0);
    send_frame(32'h000005, 32'h000006, 24, 1'b0);
    repeat (6) @(negedge sys_clk);
    chk("bp valid held", 32'(valid), 32'h1);
    chk("bp overruns", 32'(ovr_cnt - o0), 32'd2);
    chk("bp valid rises", 32'(valid_rises - v0), 32'd1);
    chk("bp data_left", 32'(data_left), 32'h000005);
    chk("bp data_right", 32'(data_right), 32'h000006);
    ready = 1'b1;
    @(negedge sys_clk);
    chk("bp accept drops valid", 32'(valid), 32'h0);
    chk("bp data kept", 32'(data_right), 32'h000006);

    // Reset released in the middle of a right slot
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2) bclk_bit(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    v0 = valid_rises;
    repeat (6) bclk_bit(1'b1, 1'b1, 1'b0);
    chk("midframe no early valid", 32'(valid), 32'h0);
    send_frame(32'h0ABCDE, 32'h0FEDCB, 24, 1'b0);
    repeat (6) @(negedge sys_clk);
    chk("midframe valid rises", 32'(valid_rises - v0), 32'd1);
    chk("midframe data_left", 32'(data_left), 32'h0ABCDE);
    chk("midframe data_right", 32'(data_right), 32'h0FEDCB);

    // Reset halfway through a left slot
    do_reset();
    ready = 1'b0;
    bclk_bit(1'b1, 1'b0, 1'b0);
    send_frame(32'h333333, 32'h444444, 24, 1'b0);
    repeat (4) @(negedge sys_clk);
    chk("rst pre valid", 32'(valid), 32'h1);
    bclk_bit(1'b0, 1'b0, 1'b0);
    for (int i = 23; i >= 12; i--) bclk_bit(1'b0, 1'(32'h555555 >> i), 1'b0);
    @(negedge sys_clk);
    reset = 1'b1;
    #1;
    chk("rst data_left", 32'(data_left), 32'h0);
    chk("rst data_right", 32'(data_right), 32'h0);
    chk("rst valid", 32'(valid), 32'h0);
    bclk = 1'b0;
    adclrc = 1'b0;
    adcdat = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    v0 = valid_rises;
    o0 = ovr_cnt;
    bclk_bit(1'b1, 1'b0, 1'b0);
    send_frame(32'h111111, 32'h222222, 24, 1'b0);
    repeat (6) @(negedge sys_clk);
    chk("post rst data_left", 32'(data_left), 32'h111111);
    chk("post rst data_right", 32'(data_right), 32'h222222);
    chk("post rst valid", 32'(valid), 32'h1);
    chk("post rst valid rises", 32'(valid_rises - v0), 32'd1);
    chk("post rst overruns", 32'(ovr_cnt - o0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
